// File: rtl/gift_round_sequencer.sv
// Iterative GIFT-128 controller: one round, key step and constant step per cycle.
// Decryption first rolls the key/constant forward to round 39, then steps them back.
//
// state  | meaning
// IDLE   | waiting for a request, outReady high
// EXPAND | decrypt only: advance key and constant to round 39
// ROUND  | one cipher round per cycle, CNT 0..39
// DONE   | result held on outData until inReady
module gift_round_sequencer #(
  parameter int ROUNDS = 40
) (
  input  logic         inClk,
  input  logic         inResetN,
  input  logic         inStart,
  output logic         outReady,
  input  logic         inDecrypt,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  input  logic [5:0]   inConstant,
  output logic [127:0] outData,
  output logic         outValid,
  input  logic         inReady,
  output logic         outBusy,
  output logic [5:0]   outRound
);

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  state_t       state;
  logic [127:0] stateReg;
  logic [127:0] keyReg;
  logic [5:0]   constReg;
  logic [5:0]   cnt;
  logic         decReg;

  logic [127:0] roundNext;
  logic [127:0] keyFwd;
  logic [127:0] keyInv;
  logic [5:0]   constFwd;
  logic [5:0]   constInv;

  function automatic logic [3:0] sbox(logic [3:0] x);
    case (x)
      4'h0: return 4'h1;  4'h1: return 4'ha;  4'h2: return 4'h4;  4'h3: return 4'hc;
      4'h4: return 4'h6;  4'h5: return 4'hf;  4'h6: return 4'h3;  4'h7: return 4'h9;
      4'h8: return 4'h2;  4'h9: return 4'hd;  4'ha: return 4'hb;  4'hb: return 4'h7;
      4'hc: return 4'h5;  4'hd: return 4'h0;  4'he: return 4'h8;  default: return 4'he;
    endcase
  endfunction

  function automatic logic [3:0] invSbox(logic [3:0] x);
    case (x)
      4'h0: return 4'hd;  4'h1: return 4'h0;  4'h2: return 4'h8;  4'h3: return 4'h6;
      4'h4: return 4'h2;  4'h5: return 4'hc;  4'h6: return 4'h4;  4'h7: return 4'hb;
      4'h8: return 4'he;  4'h9: return 4'h7;  4'ha: return 4'h1;  4'hb: return 4'ha;
      4'hc: return 4'h3;  4'hd: return 4'h9;  4'he: return 4'hf;  default: return 4'h5;
    endcase
  endfunction

  // Destination of source bit i under the GIFT-128 bit permutation.
  function automatic logic [6:0] bitPos(int i);
    return 7'(4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
  endfunction

  // Round key uses words 5,4 (U) and 1,0 (V); self-inverse, shared by both directions.
  function automatic logic [127:0] addKeyConst(logic [127:0] x, logic [127:0] k, logic [5:0] c);
    logic [127:0] y;
    y = x;
    for (int i = 0; i < 32; i++) begin
      y[4*i+2] = y[4*i+2] ^ k[64+i];
      y[4*i+1] = y[4*i+1] ^ k[i];
    end
    y[3]   = y[3]   ^ c[0];
    y[7]   = y[7]   ^ c[1];
    y[11]  = y[11]  ^ c[2];
    y[15]  = y[15]  ^ c[3];
    y[19]  = y[19]  ^ c[4];
    y[23]  = y[23]  ^ c[5];
    y[127] = ~y[127];
    return y;
  endfunction

  function automatic logic [127:0] roundFwd(logic [127:0] s, logic [127:0] k, logic [5:0] c);
    logic [127:0] t;
    logic [127:0] p;
    t = '0;
    p = '0;
    for (int i = 0; i < 32; i++) t[4*i +: 4] = sbox(s[4*i +: 4]);
    for (int i = 0; i < 128; i++) p[bitPos(i)] = t[i];
    return addKeyConst(p, k, c);
  endfunction

  function automatic logic [127:0] roundInv(logic [127:0] s, logic [127:0] k, logic [5:0] c);
    logic [127:0] y;
    logic [127:0] t;
    logic [127:0] r;
    y = addKeyConst(s, k, c);
    t = '0;
    r = '0;
    for (int i = 0; i < 128; i++) t[i] = y[bitPos(i)];
    for (int i = 0; i < 32; i++) r[4*i +: 4] = invSbox(t[4*i +: 4]);
    return r;
  endfunction

  always_comb begin
    roundNext = decReg ? roundInv(stateReg, keyReg, constReg)
                       : roundFwd(stateReg, keyReg, constReg);
    keyFwd    = {keyReg[17:16], keyReg[31:18], keyReg[11:0], keyReg[15:12], keyReg[127:32]};
    keyInv    = {keyReg[95:0], keyReg[125:112], keyReg[127:126], keyReg[99:96], keyReg[111:100]};
    constFwd  = {constReg[4:0], constReg[5] ^ constReg[4] ^ 1'b1};
    constInv  = {constReg[0] ^ constReg[5] ^ 1'b1, constReg[5:1]};
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state    <= IDLE;
      stateReg <= '0;
      keyReg   <= '0;
      constReg <= '0;
      cnt      <= '0;
      decReg   <= 1'b0;
      outData  <= '0;
      outValid <= 1'b0;
      outReady <= 1'b1;
      outBusy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inStart) begin
            stateReg <= inData;
            keyReg   <= inKey;
            constReg <= inConstant;
            decReg   <= inDecrypt;
            cnt      <= '0;
            outReady <= 1'b0;
            outBusy  <= 1'b1;
            state    <= inDecrypt ? EXPAND : ROUND;
          end
        end
        EXPAND: begin
          keyReg   <= keyFwd;
          constReg <= constFwd;
          if (cnt == 6'(ROUNDS - 2)) begin
            cnt   <= '0;
            state <= ROUND;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ROUND: begin
          stateReg <= roundNext;
          keyReg   <= decReg ? keyInv : keyFwd;
          constReg <= decReg ? constInv : constFwd;
          if (cnt == 6'(ROUNDS - 1)) begin
            cnt      <= '0;
            outData  <= roundNext;
            outValid <= 1'b1;
            outBusy  <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          if (inReady) begin
            outValid <= 1'b0;
            outReady <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign outRound = cnt;

endmodule

// File: tb/tb_gift_round_sequencer.sv
// Self-checking bench: fixed and random GIFT-128 encrypt/decrypt against an array-based model.
module tb_gift_round_sequencer;

  logic         inClk = 1'b0;
  logic         inResetN = 1'b1;
  logic         inStart = 1'b0;
  logic         inDecrypt = 1'b0;
  logic [127:0] inData = '0;
  logic [127:0] inKey = '0;
  logic [5:0]   inConstant = '0;
  logic         inReady = 1'b0;
  logic         outReady;
  logic [127:0] outData;
  logic         outValid;
  logic         outBusy;
  logic [5:0]   outRound;

  int checks = 0;
  int failures = 0;

  int permTab [128];
  logic [3:0] sboxTab [16] = '{4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
                               4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he};

  gift_round_sequencer #(.ROUNDS(40)) dut (
    .inClk(inClk), .inResetN(inResetN), .inStart(inStart), .outReady(outReady),
    .inDecrypt(inDecrypt), .inData(inData), .inKey(inKey), .inConstant(inConstant),
    .outData(outData), .outValid(outValid), .inReady(inReady), .outBusy(outBusy),
    .outRound(outRound)
  );

  always #5 inClk = ~inClk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mKeyStep(logic [127:0] key);
    logic [15:0] w [8];
    logic [15:0] n [8];
    logic [127:0] r;
    for (int i = 0; i < 8; i++) w[i] = key[16*i +: 16];
    n[7] = (w[1] >> 2) | (w[1] << 14);
    n[6] = (w[0] >> 12) | (w[0] << 4);
    for (int i = 0; i < 6; i++) n[i] = w[i+2];
    for (int i = 0; i < 8; i++) r[16*i +: 16] = n[i];
    return r;
  endfunction

  function automatic logic [5:0] mConstStep(logic [5:0] c);
    int v;
    v = ((int'(c) * 2) % 64) + (((int'(c) >> 5) ^ (int'(c) >> 4) ^ 1) & 1);
    return 6'(v);
  endfunction

  function automatic logic [127:0] mEncrypt(logic [127:0] pt, logic [127:0] key, logic [5:0] cst);
    logic b [128];
    logic n [128];
    logic [127:0] s;
    logic [127:0] k;
    logic [5:0] c;
    int cIdx [6] = '{3, 7, 11, 15, 19, 23};
    s = pt; k = key; c = cst;
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 32; j++) s[4*j +: 4] = sboxTab[s[4*j +: 4]];
      for (int i = 0; i < 128; i++) b[i] = s[i];
      for (int i = 0; i < 128; i++) n[permTab[i]] = b[i];
      for (int j = 0; j < 32; j++) begin
        n[4*j+2] ^= k[64+j];
        n[4*j+1] ^= k[j];
      end
      for (int j = 0; j < 6; j++) n[cIdx[j]] ^= c[j];
      n[127] ^= 1'b1;
      for (int i = 0; i < 128; i++) s[i] = n[i];
      k = mKeyStep(k);
      c = mConstStep(c);
    end
    return s;
  endfunction

  task automatic runOp(input logic dec, input logic [127:0] data, input logic [127:0] key,
                       input logic [5:0] cst, input bit noisy, input bit holdDone,
                       output logic [127:0] res);
    int lat;
    int expLat;
    logic [127:0] k39;
    expLat = dec ? 79 : 40;
    k39 = key;
    for (int i = 0; i < 39; i++) k39 = mKeyStep(k39);
    @(negedge inClk);
    check("readyBeforeAccept", outReady, 1);
    inDecrypt = dec; inData = data; inKey = key; inConstant = cst; inStart = 1'b1;
    @(posedge inClk); #1;
    if (!noisy) inStart = 1'b0;
    inData = {$urandom, $urandom, $urandom, $urandom};
    inKey = {$urandom, $urandom, $urandom, $urandom};
    inConstant = 6'($urandom);
    inDecrypt = ~dec;
    lat = 0;
    while (!outValid && lat < 200) begin
      if (noisy) inStart = ~inStart;
      @(posedge inClk); #1;
      lat++;
      if (lat == 20) begin
        check("roundAt20", outRound, 20);
        check("busyAt20", outBusy, 1);
        check("readyBusy", outReady, 0);
      end
      if (dec && lat == 39) begin
        check("roundStartCnt", outRound, 0);
        check("key39", dut.keyReg, k39);
      end
    end
    check(dec ? "decLatency" : "encLatency", lat, expLat);
    res = outData;
    check("busyDone", outBusy, 0);
    if (holdDone) begin
      inStart = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge inClk); #1;
        check("holdValid", outValid, 1);
        check("holdData", outData, res);
      end
    end
    inStart = 1'b0;
    inReady = 1'b1;
    @(posedge inClk); #1;
    inReady = 1'b0;
    check("idleReady", outReady, 1);
    check("idleValid", outValid, 0);
    check("idleDataKept", outData, res);
    @(posedge inClk); #1;
    check("noSecondAccept", outBusy, 0);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] res;
    logic [5:0] cst;
    int guard;
    for (int i = 0; i < 128; i++)
      permTab[i] = 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);

    #2 inResetN = 1'b0;
    #21 inResetN = 1'b1;
    @(negedge inClk);
    check("rstReady", outReady, 1);
    check("rstValid", outValid, 0);
    check("rstData", outData, 0);
    check("rstBusy", outBusy, 0);
    check("rstRound", outRound, 0);

    pt  = 128'h0123456789abcdeffedcba9876543210;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    runOp(1'b0, pt, key, 6'h01, 1'b0, 1'b0, ct);
    check("encFixed", ct, mEncrypt(pt, key, 6'h01));
    runOp(1'b1, ct, key, 6'h01, 1'b1, 1'b1, res);
    check("decFixed", res, pt);

    // Abort a decrypt mid-EXPAND.
    @(negedge inClk);
    inDecrypt = 1'b1; inData = ct; inKey = key; inConstant = 6'h01; inStart = 1'b1;
    @(posedge inClk); #1;
    inStart = 1'b0;
    guard = 0;
    while (outRound != 6'd20 && guard < 100) begin
      @(posedge inClk); #1;
      guard++;
    end
    check("reachRound20", outRound, 20);
    #2 inResetN = 1'b0;
    #1;
    check("midRstReady", outReady, 1);
    check("midRstValid", outValid, 0);
    check("midRstData", outData, 0);
    check("midRstBusy", outBusy, 0);
    check("midRstRound", outRound, 0);
    @(negedge inClk);
    inResetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge inClk); #1;
      check("noPulse", outValid, 0);
    end
    runOp(1'b0, pt, key, 6'h01, 1'b0, 1'b0, res);
    check("encAfterRst", res, mEncrypt(pt, key, 6'h01));

    for (int t = 0; t < 7; t++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = (t == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom};
      cst = (t == 0) ? 6'h3f : 6'($urandom);
      runOp(1'b0, pt, key, cst, t[0], 1'b0, ct);
      check("encRand", ct, mEncrypt(pt, key, cst));
      runOp(1'b1, ct, key, cst, t[1], t[0], res);
      check("decRand", res, pt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gift_round_sequencer.md
# gift_round_sequencer

Iterative GIFT-128 engine controller. It time-multiplexes one encryption round (GiftFullRoundFun), one decryption round (GiftFullInvRoundFun), one key-schedule step (GiftKeyschFun) and one constant step (GiftConstFun) over 40 round cycles. A built-in inverse key and constant step makes decryption possible without a 40-entry round-key store. It sits between the block-cipher mode logic and the round datapath, with a valid/ready handshake on both sides.

## Interface
Parameters:
- ROUNDS, 40: number of GIFT-128 rounds. Fixed at 40; other values are unsupported.

Ports:
- inClk  input  1  single clock; all state on the rising edge.
- inResetN  input  1  asynchronous, active-low reset.
- inStart  input  1  request valid.
- outReady  output  1  engine can accept a request; high only in IDLE.
- inDecrypt  input  1  1 = decrypt, 0 = encrypt. Sampled at accept.
- inData  input  128  plaintext or ciphertext. Sampled at accept.
- inKey  input  128  master key (round-0 key). Sampled at accept.
- inConstant  input  6  round-0 constant state; 6'h01 for standard GIFT-128. Sampled at accept.
- outData  output  128  result. Registered; stable while outValid is high.
- outValid  output  1  result valid.
- inReady  input  1  consumer accepts the result.
- outBusy  output  1  high in EXPAND or ROUND.
- outRound  output  6  current round/step counter, for debug.

## Operation
- Registers: state register S[127:0], key register K[127:0], constant register C[5:0], counter CNT[5:0], mode flag D, FSM state.
- IDLE:
  - outReady = 1.
  - Accept happens when inStart && outReady. At that edge: S←inData, K←inKey, C←inConstant, D←inDecrypt, CNT←0.
  - Next state is ROUND if D = 0, otherwise EXPAND.
- EXPAND (decrypt only):
  - Each cycle: K←GiftKeyschFun(K), C←GiftConstFun(C), CNT←CNT+1.
  - After 39 steps (CNT reaches 38 → exit), K and C hold the round-39 key and constant. CNT←0, go to ROUND.
- ROUND, encrypt:
  - Each cycle: S←GiftFullRoundFun(S, K, C), K←GiftKeyschFun(K), C←GiftConstFun(C).
- ROUND, decrypt:
  - Each cycle: S←GiftFullInvRoundFun(S, K, C), K←invKey(K), C←invConst(C).
  - invKey: with K = N7..N0 as 16-bit words (N7 = K[127:112]), result is {N5, N4, N3, N2, N1, N0, N7 rotl 2, N6 rotl 12}.
  - invConst: for c = n5..n0, result is {n0^n5^1, n5, n4, n3, n2, n1}.
  - Required identities for all x: GiftKeyschFun(invKey(x)) = x and GiftConstFun(invConst(x)) = x.
- ROUND exit: CNT counts 0..39. On the edge where CNT = 39, outData←next S, outValid←1, go to DONE. CNT wraps to 0.
- DONE:
  - outValid = 1; outData is held.
  - On outValid && inReady: outValid←0, go to IDLE. outData keeps its last value.
- inStart outside IDLE is ignored; no queueing.
- inData, inKey, inConstant and inDecrypt changes after the accept edge have no effect.
- K and C after the operation are don't-care. They are not exposed.

## Timing
- Reset (async assert, sync release): FSM = IDLE, S/K/C/CNT/D = 0, outData = 0, outValid = 0, outBusy = 0, outReady = 1, outRound = 0.
- Encrypt latency: 40 cycles from the accept edge to outValid high (rising edge number 40 after accept).
- Decrypt latency: 79 cycles (39 EXPAND + 40 ROUND).
- Minimum request spacing:
  - Encrypt: 42 cycles (40 + DONE handshake + IDLE).
  - Decrypt: 81 cycles.
- Reset asserted mid-operation: everything returns to reset values immediately. The partial result is discarded; outValid never pulses.
- Backpressure: DONE holds for any number of cycles while inReady = 0.
- inReady outside DONE is ignored.
- Combinational path per cycle: one round function plus key and constant step muxed by D. No input→output combinational path.

## Test plan
- Reset: assert inResetN = 0 mid-cycle, then release. Required: outReady = 1, outValid = 0, outData = 0, outBusy = 0, outRound = 0.
- Encrypt:
  - Stimulus: inData = 128'h0123456789abcdeffedcba9876543210, inKey = 128'h000102030405060708090a0b0c0d0e0f, inConstant = 6'h01, inDecrypt = 0.
  - Required: outValid rises exactly 40 cycles after accept.
  - Required: outData equals the software model of 40 chained rounds.
- Decrypt:
  - Stimulus: feed the ciphertext from the encrypt test with the same key and constant, inDecrypt = 1.
  - Required: outValid at 79 cycles; outData = 128'h0123456789abcdeffedcba9876543210.
  - Required: at CNT = 0 of ROUND, K equals the 39th forward key.
- Backpressure and busy:
  - Stimulus: hold inReady = 0 for 5 cycles in DONE; toggle inStart = 1 throughout EXPAND, ROUND and DONE.
  - Required: outData and outValid stable; no second accept.
  - Required: after inReady = 1, return to IDLE and outReady = 1 the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset during decrypt EXPAND at outRound = 20, then run a fresh encrypt.
  - Required: immediate reset values, no outValid pulse, and a correct encrypt result.
- Inverse-step properties: for 1000 random x, GiftKeyschFun(invKey(x)) = x and GiftConstFun(invConst(x)) = x. This includes x = all-ones and 6'h3f.
